// File: rtl/rx_buffer_ctrl_pkg.sv
// Shared types and constants for the UART receive buffer: occupancy states,
// entry field layout and character-size codes.
package rx_buffer_ctrl_pkg;

  localparam int unsigned DATA_W   = 9;
  localparam int unsigned ENTRY_W  = 12;
  localparam int unsigned DOR_BIT  = 11;
  localparam int unsigned FE_BIT   = 10;
  localparam int unsigned PE_BIT   = 9;
  localparam int unsigned DATA_MSB = 8;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [2:0] UCSZ_5 = 3'b000;
  localparam logic [2:0] UCSZ_6 = 3'b001;
  localparam logic [2:0] UCSZ_7 = 3'b010;
  localparam logic [2:0] UCSZ_8 = 3'b011;
  localparam logic [2:0] UCSZ_9 = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic              dor;
    logic              fe;
    logic              pe;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  // Data mask for a character-size code; reserved codes mask everything off.
  function automatic logic [DATA_W-1:0] ucsz_mask(input logic [2:0] ucsz);
    logic [DATA_W-1:0] m;
    case (ucsz)
      UCSZ_5:  m = 9'h01F;
      UCSZ_6:  m = 9'h03F;
      UCSZ_7:  m = 9'h07F;
      UCSZ_8:  m = 9'h0FF;
      UCSZ_9:  m = 9'h1FF;
      default: m = 9'h000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Receive FIFO storage with wrapping read/write pointers and in-place
// overrun marking of the newest entry.
module rx_fifo_mem
  import rx_buffer_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_wr_en,
  input  logic [ENTRY_W-1:0] i_wr_entry,
  input  logic               i_rd_en,
  input  logic               i_set_dor,
  output logic [ENTRY_W-1:0] o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   tail_ptr;

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (i_wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (i_rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  assign tail_ptr = wr_ptr_q - PTR_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Write and overrun marking never coincide: marking only happens when full with no read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (i_wr_en)   mem_q[wr_ptr_q]          <= i_wr_entry;
      if (i_set_dor) mem_q[tail_ptr][DOR_BIT] <= 1'b1;
    end
  end

  assign o_head = mem_q[rd_ptr_q];

endmodule

// File: rtl/rx_buffer_ctrl.sv
// UART receive buffer controller: occupancy FSM, overrun handling and
// character-size masking in front of a small receive FIFO.
module rx_buffer_ctrl
  import rx_buffer_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rxen,
  input  logic [2:0]        i_ucsz,
  input  logic              i_rxcie,
  input  logic [DATA_W-1:0] i_shift_register,
  input  logic              i_shift_register_valid,
  input  logic              i_frame_error,
  input  logic              i_parity_error,
  input  logic              i_udr_rd,
  output logic [DATA_W-1:0] o_udr,
  output logic              o_fe,
  output logic              o_pe,
  output logic              o_dor,
  output logic              o_rxc,
  output logic              o_rx_irq,
  output logic              o_udr_valid,
  output logic              o_receive_buffer_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  occ_state_e         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rd_acc, wr_acc, set_dor;
  rx_entry_t          wr_entry;
  logic [ENTRY_W-1:0] head_raw;
  logic               head_vld;

  // A read in FULL frees the slot first, so a same-cycle write is accepted.
  always_comb begin
    rd_acc  = 1'b0;
    wr_acc  = 1'b0;
    set_dor = 1'b0;
    count_d = count_q;
    state_d = state_q;
    if (!i_rxen) begin
      count_d = '0;
    end else begin
      rd_acc = i_udr_rd && (state_q != ST_EMPTY);
      if (i_shift_register_valid) begin
        if ((state_q != ST_FULL) || rd_acc) wr_acc  = 1'b1;
        else                                set_dor = 1'b1;
      end
      count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end
    if (count_d == '0)                 state_d = ST_EMPTY;
    else if (count_d == CNT_W'(DEPTH)) state_d = ST_FULL;
    else                               state_d = ST_PARTIAL;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.dor  = 1'b0;
    wr_entry.fe   = i_frame_error;
    wr_entry.pe   = i_parity_error;
    wr_entry.data = i_shift_register;
  end

  rx_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (!i_rxen),
    .i_wr_en    (wr_acc),
    .i_wr_entry (wr_entry),
    .i_rd_en    (rd_acc),
    .i_set_dor  (set_dor),
    .o_head     (head_raw)
  );

  // Head view is gated by occupancy so a stale entry never leaks out when empty.
  assign head_vld               = (state_q != ST_EMPTY);
  assign o_udr                  = head_vld ? (head_raw[DATA_MSB:DATA_LSB] & ucsz_mask(i_ucsz)) : '0;
  assign o_fe                   = head_vld & head_raw[FE_BIT];
  assign o_pe                   = head_vld & head_raw[PE_BIT];
  assign o_dor                  = head_vld & head_raw[DOR_BIT];
  assign o_rxc                  = head_vld;
  assign o_rx_irq               = head_vld & i_rxcie;
  assign o_udr_valid            = head_vld;
  assign o_receive_buffer_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Scoreboard bench for rx_buffer_ctrl: a queue-based reference model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_rx_buffer_ctrl;

  localparam int unsigned DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxen;
  logic [2:0] ucsz;
  logic       rxcie;
  logic [8:0] sr;
  logic       sr_valid;
  logic       fe_in;
  logic       pe_in;
  logic       udr_rd;
  logic [8:0] o_udr;
  logic       o_fe, o_pe, o_dor, o_rxc, o_rx_irq, o_udr_valid, o_receive_buffer_valid;

  always #5 clk = ~clk;

  rx_buffer_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_rxen                 (rxen),
    .i_ucsz                 (ucsz),
    .i_rxcie                (rxcie),
    .i_shift_register       (sr),
    .i_shift_register_valid (sr_valid),
    .i_frame_error          (fe_in),
    .i_parity_error         (pe_in),
    .i_udr_rd               (udr_rd),
    .o_udr                  (o_udr),
    .o_fe                   (o_fe),
    .o_pe                   (o_pe),
    .o_dor                  (o_dor),
    .o_rxc                  (o_rxc),
    .o_rx_irq               (o_rx_irq),
    .o_udr_valid            (o_udr_valid),
    .o_receive_buffer_valid (o_receive_buffer_valid)
  );

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       dor;
  } ment_t;

  typedef struct packed {
    logic       rxc;
    logic       full;
    logic       irq;
    logic       uv;
    logic [8:0] udr;
    logic       fe;
    logic       pe;
    logic       dor;
  } obs_t;

  ment_t model[$];
  obs_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  function automatic logic [8:0] size_mask(input logic [2:0] code);
    int bits;
    if (code <= 3'd3)      bits = 5 + int'(code);
    else if (code == 3'd7) bits = 9;
    else                   bits = 0;
    return 9'((1 << bits) - 1);
  endfunction

  function automatic obs_t model_obs(input logic [2:0] code, input logic cie);
    obs_t o;
    o = '0;
    if (model.size() > 0) begin
      o.rxc  = 1'b1;
      o.uv   = 1'b1;
      o.irq  = cie;
      o.full = (model.size() == int'(DEPTH));
      o.udr  = model[0].data & size_mask(code);
      o.fe   = model[0].fe;
      o.pe   = model[0].pe;
      o.dor  = model[0].dor;
    end
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return {o_rxc, o_receive_buffer_valid, o_rx_irq, o_udr_valid, o_udr, o_fe, o_pe, o_dor};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got rxc=%0b full=%0b irq=%0b valid=%0b udr=%03h fe=%0b pe=%0b dor=%0b, expected rxc=%0b full=%0b irq=%0b valid=%0b udr=%03h fe=%0b pe=%0b dor=%0b",
               name, got.rxc, got.full, got.irq, got.uv, got.udr, got.fe, got.pe, got.dor,
               want.rxc, want.full, want.irq, want.uv, want.udr, want.fe, want.pe, want.dor);
    end
  endtask

  // Reference behaviour: disable empties, a read pops the oldest, a write lands
  // if there is room after the read, otherwise the newest entry gets the overrun flag.
  task automatic model_apply(input logic v, input logic [8:0] d, input logic f,
                             input logic p, input logic rd, input logic en);
    ment_t e;
    if (!en) begin
      model.delete();
      return;
    end
    if (rd && model.size() > 0) void'(model.pop_front());
    if (v) begin
      if (model.size() < int'(DEPTH)) begin
        e.data = d;
        e.fe   = f;
        e.pe   = p;
        e.dor  = 1'b0;
        model.push_back(e);
      end else begin
        e = model[model.size()-1];
        e.dor = 1'b1;
        model[model.size()-1] = e;
      end
    end
  endtask

  task automatic step(input logic v, input logic [8:0] d, input logic f, input logic p,
                      input logic rd, input logic en, input logic [2:0] code, input logic cie);
    @(posedge clk);
    #2;
    sr_valid = v;
    sr       = d;
    fe_in    = f;
    pe_in    = p;
    udr_rd   = rd;
    rxen     = en;
    ucsz     = code;
    rxcie    = cie;
    exp_q.push_back(model_obs(code, cie));
    model_apply(v, d, f, p, rd, en);
  endtask

  task automatic wr(input logic [8:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0);
  endtask

  task automatic rd_op();
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0);
  endtask

  task automatic idle(input logic [2:0] code);
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, code, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst      = 1'b1;
    sr_valid = 1'b0;
    udr_rd   = 1'b0;
    #1;
    check("rst_mid", dut_obs(), obs_t'(0));
    model.delete();
    exp_q.push_back(obs_t'(0));
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    obs_t w;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      cyc++;
      check($sformatf("cyc%0d", cyc), dut_obs(), w);
    end
  end

  initial begin
    rst = 1'b1; rxen = 1'b1; ucsz = 3'b011; rxcie = 1'b0;
    sr = '0; sr_valid = 1'b0; fe_in = 1'b0; pe_in = 1'b0; udr_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_obs(), obs_t'(0));
    @(negedge clk);
    rst = 1'b0;

    // single frame
    wr(9'h0A5); idle(3'b011); rd_op(); idle(3'b011);
    // overrun on full
    wr(9'h011); wr(9'h022); wr(9'h033); idle(3'b011); rd_op(); idle(3'b011); rd_op(); idle(3'b011);
    // simultaneous read and write while full
    wr(9'h011); wr(9'h022);
    step(1'b1, 9'h044, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0);
    idle(3'b011); rd_op(); rd_op(); idle(3'b011);
    // simultaneous read and write while empty
    step(1'b1, 9'h055, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0);
    idle(3'b011); rd_op();
    // character-size masking
    wr(9'h1FF); idle(3'b000); idle(3'b111); idle(3'b100); idle(3'b001); rd_op(); idle(3'b011);
    // error flags and interrupt
    step(1'b1, 9'h0C3, 1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 1'b1);
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1);
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 1'b1);
    step(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 1'b1);
    // flush, then reset mid-stream
    wr(9'h101); wr(9'h102);
    step(1'b1, 9'h103, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 1'b0);
    idle(3'b011);
    wr(9'h104); wr(9'h105); idle(3'b011);
    mid_reset();
    idle(3'b011);

    for (int n = 0; n < 600; n++) begin
      logic [2:0] code;
      logic [2:0] codes [6];
      codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010;
      codes[3] = 3'b011; codes[4] = 3'b111; codes[5] = 3'b101;
      code = codes[$urandom_range(0, 5)];
      if ($urandom_range(0, 79) == 0) begin
        mid_reset();
      end else begin
        step(1'($urandom_range(0, 1)), 9'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 19) != 0), code, 1'($urandom_range(0, 1)));
      end
    end

    idle(3'b011);
    idle(3'b011);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_buffer_ctrl.md
RX_BUFFER_CTRL -- requirements
Module: rx_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the receive FIFO depth in entries; legal values are 2 and 4.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock (receiver clock domain).
REQ-003 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_rxen, input, 1 bit: receiver enable; 0 flushes the FIFO.
REQ-005 The block SHALL have port i_ucsz, input, 3 bits: character size code (000=5 … 011=8, 111=9, others reserved).
REQ-006 The block SHALL have port i_rxcie, input, 1 bit: receive-complete interrupt enable.
REQ-007 The block SHALL have port i_shift_register, input, 9 bits: received frame from the receiver.
REQ-008 The block SHALL have port i_shift_register_valid, input, 1 bit: one-cycle frame-complete strobe.
REQ-009 The block SHALL have port i_frame_error, input, 1 bit: frame error for the current frame.
REQ-010 The block SHALL have port i_parity_error, input, 1 bit: parity error for the current frame.
REQ-011 The block SHALL have port i_udr_rd, input, 1 bit: one-cycle CPU read strobe of the head entry.
REQ-012 The block SHALL have port o_udr, output, 9 bits: head-entry data, masked to the character size.
REQ-013 The block SHALL have port o_fe, output, 1 bit: head-entry frame error.
REQ-014 The block SHALL have port o_pe, output, 1 bit: head-entry parity error.
REQ-015 The block SHALL have port o_dor, output, 1 bit: head-entry data overrun.
REQ-016 The block SHALL have port o_rxc, output, 1 bit: FIFO not empty.
REQ-017 The block SHALL have port o_rx_irq, output, 1 bit: o_rxc & i_rxcie.
REQ-018 The block SHALL have port o_udr_valid, output, 1 bit: FIFO not empty (feeds receiver i_udr_valid).
REQ-019 The block SHALL have port o_receive_buffer_valid, output, 1 bit: FIFO full (feeds receiver i_receive_buffer_valid).

Function
REQ-020 The FIFO SHALL store entries of 12 bits: {dor, fe, pe, data[8:0]}, using a read pointer, a write pointer and a count of width clog2(DEPTH)+1.
REQ-021 An occupancy FSM SHALL have states EMPTY, PARTIAL and FULL, derived registered from count (0, 1..DEPTH-1, DEPTH).
REQ-022 On a valid strobe in EMPTY or PARTIAL, the block SHALL write {0, i_frame_error, i_parity_error, i_shift_register}, advance the write pointer and increment count.
REQ-023 On a valid strobe in FULL, the block SHALL drop the frame, leave the pointers unchanged, and set the dor bit of the newest (tail) entry.
REQ-024 On a read strobe in PARTIAL or FULL, the block SHALL advance the read pointer and decrement count; a read in EMPTY SHALL be ignored.
REQ-025 On a simultaneous write and read in PARTIAL, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 On a simultaneous write and read in FULL, the write SHALL be accepted (read frees the slot first) and no overrun SHALL be set.
REQ-027 On a simultaneous write and read in EMPTY, the write SHALL be accepted and the read ignored.
REQ-028 Pointers SHALL wrap modulo DEPTH.
REQ-029 The head outputs SHALL be combinational from the head entry; they SHALL read 0 when EMPTY.
REQ-030 o_udr SHALL mask the head data bits at or above the character size (5-bit keeps [4:0], 9-bit keeps [8:0]); a reserved size code SHALL yield 0.
REQ-031 Latency SHALL be: a write is visible at the head and in o_rxc the cycle after the strobe; a read updates the head the cycle after the strobe.
REQ-032 When i_rxen=0, the block SHALL clear pointers and count synchronously each cycle and ignore both strobes.

Reset
REQ-033 While i_rst=1, the block SHALL asynchronously clear pointers, count and all entry storage; the FSM SHALL go to EMPTY.
REQ-034 During reset, all outputs SHALL be 0.
REQ-035 Assertion of i_rst mid-operation SHALL discard stored frames with no partial entry retained.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the entry field offsets (DOR=11, FE=10, PE=9, DATA=8:0) and the UCSZ code constants.
REQ-037 The storage array plus pointers SHALL be the sub-module rx_fifo_mem; the FSM, overrun logic and masking SHALL stay in rx_buffer_ctrl.

Verification
REQ-038 Single frame: valid with data 0x0A5, ucsz=011 -> o_rxc=1 next cycle, o_udr=0x0A5, fe=pe=dor=0; read -> o_rxc=0.
REQ-039 Overrun: DEPTH=2; write 0x011, 0x022, then 0x033 -> 0x033 is lost; read gives 0x011 with dor=0; second read gives 0x022 with dor=1.
REQ-040 Simultaneous events: FULL plus read and write of 0x044 in the same cycle -> count stays 2, no dor, order is 0x022 then 0x044.
REQ-041 Masking: store 0x1FF with ucsz=000 -> o_udr=0x01F; with ucsz=111 -> 0x1FF; with ucsz=100 -> 0x000.
REQ-042 Flush and reset: two entries stored, then i_rxen=0 for one cycle -> o_rxc=0; refill, assert i_rst mid-stream -> all outputs 0 immediately.
REQ-043 Error flags: frame with fe=1, pe=1 and rxcie=1 -> o_fe=o_pe=1 and o_rx_irq=1 until read.
